// File: rtl/axi_axis_writer_if.sv
// Bus bundle for axi_axis_writer: the AXI4-Lite slave channels (AW, W, B, AR, R)
// and the AXI4-Stream master channel (m_axis_*).
//   slave  modport : view of the writer block (accepts AXI-Lite, drives the stream)
//   master modport : view of the environment (CPU side driving AXI-Lite, stream sink)
// Widths are parameters so the same bundle serves narrow and wide stream variants.
interface axi_axis_writer_if #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 12,
    parameter int AXIS_DATA_WIDTH = 32
);
    // AXI4-Lite write address / data / response
    logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr;
    logic                       s_axi_awvalid;
    logic                       s_axi_awready;
    logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata;
    logic                       s_axi_wvalid;
    logic                       s_axi_wready;
    logic [1:0]                 s_axi_bresp;
    logic                       s_axi_bvalid;
    logic                       s_axi_bready;
    // AXI4-Lite read address / data
    logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr;
    logic                       s_axi_arvalid;
    logic                       s_axi_arready;
    logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata;
    logic [1:0]                 s_axi_rresp;
    logic                       s_axi_rvalid;
    logic                       s_axi_rready;
    // AXI4-Stream master
    logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata;
    logic                       m_axis_tvalid;
    logic                       m_axis_tready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output m_axis_tdata, m_axis_tvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/axi_axis_writer.sv
// axi_axis_writer: AXI4-Lite slave that queues CPU writes to the DATA register in a
// FIFO and presents them in write order on an AXI4-Stream master port.
// Register map (word index = addr[AXI_ADDR_WIDTH-1:2], addr[1:0] ignored):
//   idx0 write : DATA   - push word (SLVERR + sticky overflow when full)
//   idx1 write : CTRL   - bit0 clears overflow, bit1 flushes the FIFO
//   idx0 read  : STATUS - [15:0] count, [16] empty, [17] full, [18] overflow
//   idx1 read  : FREE   - FIFO_DEPTH - count
//   other      : writes ignored (OKAY), reads return 0
// Ports:
//   aclk   - clock, all logic on the rising edge
//   areset - synchronous reset, active-high
//   bus    - axi_axis_writer_if.slave (AXI4-Lite slave + AXI4-Stream master)
module axi_axis_writer #(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 12,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic             aclk,
    input  logic             areset,
    axi_axis_writer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = AXI_ADDR_WIDTH - 2;

    localparam logic [IDX_W-1:0] IDX_DATA    = '0;
    localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    // Write-channel latches: AW and W are captured independently and held
    // until the B handshake retires the transaction.
    logic                      aw_full_q, aw_full_d;
    logic [IDX_W-1:0]          aw_idx_q, aw_idx_d;
    logic                      w_full_q, w_full_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      rvalid_q, rvalid_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      overflow_q, overflow_d;

    // FIFO state
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [AXIS_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AXIS_DATA_WIDTH-1:0] push_data;

    logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                      commit, is_full, push, pop, flush;
    logic [IDX_W-1:0]          rd_idx;
    logic [AXI_DATA_WIDTH-1:0] status_word, free_word;

    // Map the AXI-Lite word onto the stream width.
    generate
        if (AXIS_DATA_WIDTH == AXI_DATA_WIDTH) begin : g_same
            assign push_data = w_data_q;
        end else if (AXIS_DATA_WIDTH < AXI_DATA_WIDTH) begin : g_narrow
            assign push_data = w_data_q[AXIS_DATA_WIDTH-1:0];
        end else begin : g_wide
            assign push_data = {w_data_q, {(AXIS_DATA_WIDTH - AXI_DATA_WIDTH){1'b0}}};
        end
    endgenerate

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can
        // leave it unassigned and infer a latch.
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_idx     = bus.s_axi_araddr[AXI_ADDR_WIDTH-1:2];

        aw_hs  = bus.s_axi_awvalid && !aw_full_q;
        w_hs   = bus.s_axi_wvalid && !w_full_q;
        b_hs   = bvalid_q && bus.s_axi_bready;
        ar_hs  = bus.s_axi_arvalid && !rvalid_q;
        r_hs   = rvalid_q && bus.s_axi_rready;

        // Commit once both halves are held and no response is outstanding.
        commit  = aw_full_q && w_full_q && !bvalid_q;
        // Fullness is judged on the pre-edge count: a same-edge pop never makes room.
        is_full = (count_q == DEPTH_CNT);
        pop     = (count_q != '0) && bus.m_axis_tready;
        push    = commit && (aw_idx_q == IDX_DATA) && !is_full;
        flush   = commit && (aw_idx_q == IDX_CTRL) && w_data_q[1];

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = bus.s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = bus.s_axi_wdata;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            if (aw_idx_q == IDX_DATA && is_full) begin
                bresp_d    = RESP_SLVERR;
                overflow_d = 1'b1;
            end
            if (aw_idx_q == IDX_CTRL && w_data_q[0]) begin
                overflow_d = 1'b0;
            end
        end

        // Ready lines reopen on the edge after the response is taken.
        if (b_hs) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        // Flush wins over a concurrent pop; the popped word is simply discarded.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Read data reflects the state after the AR handshake edge.
        status_word              = '0;
        status_word[CNT_W-1:0]   = count_d;
        status_word[16]          = (count_d == '0);
        status_word[17]          = (count_d == DEPTH_CNT);
        status_word[18]          = overflow_d;
        free_word                = '0;
        free_word[CNT_W-1:0]     = DEPTH_CNT - count_d;

        if (r_hs) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (rd_idx == IDX_DATA) begin
                rdata_d = status_word;
            end else if (rd_idx == IDX_CTRL) begin
                rdata_d = free_word;
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (areset) begin
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the count and pointers
    // define which entries are valid, so clearing the array would buy nothing.
    always_ff @(posedge aclk) begin
        if (!areset && push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    assign bus.s_axi_awready = !aw_full_q;
    assign bus.s_axi_wready  = !w_full_q;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_arready = !rvalid_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rresp   = RESP_OKAY;
    assign bus.m_axis_tvalid = (count_q != '0);
    assign bus.m_axis_tdata  = fifo_mem[rd_ptr_q];

    // Address byte-lane bits and unused data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0], w_data_q};
endmodule
